// File: rtl/nueve_b.sv
// nueve_b: registered classifier of N = {a,b,c,d}; x = prime, y = multiple of 3.
// Optional macro NUEVE_B_SYNC_EN adds a 2-flop synchronizer per input (latency 3 instead of 1).
module nueve_b (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic x,
   output logic y
);

   localparam int unsigned N_W = 4;

   logic [N_W-1:0] n_raw;
   logic [N_W-1:0] n;
   logic           prime_c;
   logic           mult3_c;

   assign n_raw = {a, b, c, d};

`ifdef NUEVE_B_SYNC_EN
   logic [N_W-1:0] sync1;
   logic [N_W-1:0] sync2;

   // Two-stage synchronizer per bit; cleared so the pipeline presents N = 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= n_raw;
         sync2 <= sync1;
      end
   end

   assign n = sync2;
`else
   assign n = n_raw;
`endif

   // Unknown codes fall to the default arm, so X/Z never reaches the flags.
   always_comb begin
      prime_c = 1'b0;
      mult3_c = 1'b0;
      case (n)
         4'd0:  mult3_c = 1'b1;
         4'd2:  prime_c = 1'b1;
         4'd3:  begin prime_c = 1'b1; mult3_c = 1'b1; end
         4'd5:  prime_c = 1'b1;
         4'd6:  mult3_c = 1'b1;
         4'd7:  prime_c = 1'b1;
         4'd9:  mult3_c = 1'b1;
         4'd11: prime_c = 1'b1;
         4'd12: mult3_c = 1'b1;
         4'd13: prime_c = 1'b1;
         4'd15: mult3_c = 1'b1;
         default: begin
            prime_c = 1'b0;
            mult3_c = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= 1'b0;
         y <= 1'b0;
      end else begin
         x <= prime_c;
         y <= mult3_c;
      end
   end

endmodule

// File: tb/tb_nueve_b.sv
// Directed self-checking bench for nueve_b; expected latency follows NUEVE_B_SYNC_EN.
module tb_nueve_b;

`ifdef NUEVE_B_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
   logic x, y;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_x_seq = 16'b0010_1000_1010_1100;
   logic [15:0] exp_y_seq = 16'b1001_0010_0100_1001;

   nueve_b dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .x(x), .y(y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic set_n(input logic [3:0] v);
      {a, b, c, d} = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Fill the pipeline with 1111 so the reset clearing is visible.
      set_n(4'b1111);
      repeat (LAT + 2) tick();
      chk("pre_reset_x", x, 1'b0);
      chk("pre_reset_y", y, 1'b1);

      #2 rst = 1'b1;
      #1;
      chk("reset_async_x", x, 1'b0);
      chk("reset_async_y", y, 1'b0);
      repeat (2) tick();
      chk("reset_held_x", x, 1'b0);
      chk("reset_held_y", y, 1'b0);

      // Release with inputs at 0000: y rises at the latency.
      set_n(4'b0000);
      #2 rst = 1'b0;
      repeat (LAT) tick();
      chk("release_y", y, 1'b1);
      chk("release_x", x, 1'b0);

      // Exhaustive sweep, one value per cycle.
      for (int j = 0; j < 16 + LAT - 1; j++) begin
         if (j < 16) set_n(4'(j));
         tick();
         if (j >= LAT - 1) begin
            chk($sformatf("sweep_x_%0d", j - LAT + 1), x, exp_x_seq[j-LAT+1]);
            chk($sformatf("sweep_y_%0d", j - LAT + 1), y, exp_y_seq[j-LAT+1]);
         end
      end

      // Overlap: N = 3 sets both flags.
      set_n(4'b0011);
      repeat (LAT + 1) tick();
      chk("overlap_x", x, 1'b1);
      chk("overlap_y", y, 1'b1);

      // Latency: 0000 -> 1101 at a known edge.
      set_n(4'b0000);
      repeat (LAT + 1) tick();
      chk("lat_base_x", x, 1'b0);
      chk("lat_base_y", y, 1'b1);
      set_n(4'b1101);
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k < LAT) begin
            chk($sformatf("lat_early_x_%0d", k), x, 1'b0);
            chk($sformatf("lat_early_y_%0d", k), y, 1'b1);
         end else begin
            chk("lat_edge_x", x, 1'b1);
            chk("lat_edge_y", y, 1'b0);
         end
      end

      // Mid-stream reset while sweeping.
      set_n(4'd6);
      tick();
      set_n(4'd7);
      tick();
      set_n(4'd5);
      #2 rst = 1'b1;
      #1;
      chk("mid_reset_x", x, 1'b0);
      chk("mid_reset_y", y, 1'b0);
      tick();
      chk("mid_reset_hold_x", x, 1'b0);
      chk("mid_reset_hold_y", y, 1'b0);
      #2 rst = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k < LAT) begin
            chk($sformatf("mid_resume_early_x_%0d", k), x, 1'b0);
            chk($sformatf("mid_resume_early_y_%0d", k), y, 1'b1);
         end else begin
            chk("mid_resume_x", x, 1'b1);
            chk("mid_resume_y", y, 1'b0);
         end
      end

      // Stability: hold N = 9.
      set_n(4'd9);
      repeat (LAT) tick();
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("stable_x_%0d", k), x, 1'b0);
         chk($sformatf("stable_y_%0d", k), y, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
